// File: rtl/frame_unpack_demux.sv
// Header-framed 64-bit word stream to tagged byte stream unpacker.
// Define FRAME_UNPACK_CHECKSUM_EN for an XOR trailer word after the payload.
module frame_unpack_demux #(
  parameter int          NUM_CH    = 4,
  parameter int          MAX_LEN   = 255,
  parameter logic [15:0] HDR_MAGIC = 16'hA55A
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [63:0]               in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                out_byte,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last,
  output logic                      err_hdr,
  output logic                      err_chk,
  output logic [15:0]               frame_cnt
);

  localparam int CW = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    HUNT,
    LOAD,
    EMIT,
    CHK
  } state_t;

`ifdef FRAME_UNPACK_CHECKSUM_EN
  localparam state_t AFTER_LAST = CHK;
`else
  localparam state_t AFTER_LAST = HUNT;
`endif

  state_t        state;
  state_t        nxt;
  logic          live;
  logic [63:0]   sreg;
  logic [2:0]    byte_idx;
  logic [15:0]   words_left;
  logic [CW-1:0] ch;
  logic [15:0]   cnt;
  logic          err_hdr_q;

  logic [15:0] hdr_len;
  logic        hdr_ok;
  logic        accept;
  logic        fire;
  logic        word_done;
  logic        last_word;
  logic        hdr_take;
  logic        load_take;
  logic        frame_done;

  assign hdr_len = in_data[15:0];
  assign hdr_ok  = (in_data[63:48] == HDR_MAGIC)
                && (in_data[47:40] < 8'(NUM_CH))
                && (hdr_len != 16'd0)
                && (hdr_len <= 16'(MAX_LEN));

  // live holds in_ready low for the first cycle after reset
  assign in_ready  = live && (state != EMIT);
  assign out_valid = (state == EMIT);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign word_done = fire && (byte_idx == 3'd7);
  assign last_word = (words_left == 16'd1);
  assign hdr_take  = accept && (state == HUNT) && hdr_ok;
  assign load_take = accept && (state == LOAD);

  assign out_byte  = out_valid ? sreg[63:56] : 8'h00;
  assign out_ch    = out_valid ? ch : '0;
  assign out_last  = out_valid && (byte_idx == 3'd7) && last_word;
  assign err_hdr   = err_hdr_q;
  assign frame_cnt = cnt;

`ifdef FRAME_UNPACK_CHECKSUM_EN
  assign frame_done = accept && (state == CHK);
`else
  assign frame_done = word_done && last_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      HUNT: if (hdr_take) nxt = LOAD;
      LOAD: if (load_take) nxt = EMIT;
      EMIT: begin
        if (word_done) begin
          nxt = last_word ? AFTER_LAST : LOAD;
        end
      end
`ifdef FRAME_UNPACK_CHECKSUM_EN
      CHK: if (accept) nxt = HUNT;
`endif
      default: nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live       <= 1'b0;
      sreg       <= '0;
      byte_idx   <= '0;
      words_left <= '0;
      ch         <= '0;
      cnt        <= '0;
      err_hdr_q  <= 1'b0;
    end else begin
      live      <= 1'b1;
      err_hdr_q <= accept && (state == HUNT) && !hdr_ok;
      if (hdr_take) begin
        ch         <= in_data[40 +: CW];
        words_left <= hdr_len;
      end
      if (load_take) begin
        sreg     <= in_data;
        byte_idx <= 3'd0;
      end
      if (fire) begin
        sreg     <= {sreg[55:0], 8'h00};
        byte_idx <= byte_idx + 3'd1;
        if (byte_idx == 3'd7) begin
          words_left <= words_left - 16'd1;
        end
      end
      if (frame_done) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

`ifdef FRAME_UNPACK_CHECKSUM_EN
  logic [63:0] csum;
  logic        err_chk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum      <= '0;
      err_chk_q <= 1'b0;
    end else begin
      err_chk_q <= accept && (state == CHK) && (in_data != csum);
      if (hdr_take) begin
        csum <= '0;
      end else if (load_take) begin
        csum <= csum ^ in_data;
      end
    end
  end

  assign err_chk = err_chk_q;
`else
  assign err_chk = 1'b0;
`endif

endmodule
